// File: rtl/segment_pkg.sv
// -----------------------------------------------------------------------------
// segment_pkg
// Shared definitions for the serial 7-segment display driver:
//   - segment byte width and default digit count
//   - active-high segment patterns, byte layout {dp,g,f,e,d,c,b,a}
//   - frame sequencer state encoding
//   - bcd_to_seg(): BCD nibble to segment byte (non-decimal nibbles go dark)
// -----------------------------------------------------------------------------
package segment_pkg;

  localparam int SEG_BITS           = 8;
  localparam int DEFAULT_NUM_DIGITS = 11;

  localparam logic [SEG_BITS-1:0] SEG_0   = 8'h3F;
  localparam logic [SEG_BITS-1:0] SEG_1   = 8'h06;
  localparam logic [SEG_BITS-1:0] SEG_2   = 8'h5B;
  localparam logic [SEG_BITS-1:0] SEG_3   = 8'h4F;
  localparam logic [SEG_BITS-1:0] SEG_4   = 8'h66;
  localparam logic [SEG_BITS-1:0] SEG_5   = 8'h6D;
  localparam logic [SEG_BITS-1:0] SEG_6   = 8'h7D;
  localparam logic [SEG_BITS-1:0] SEG_7   = 8'h07;
  localparam logic [SEG_BITS-1:0] SEG_8   = 8'h7F;
  localparam logic [SEG_BITS-1:0] SEG_9   = 8'h6F;
  localparam logic [SEG_BITS-1:0] SEG_OFF = 8'h00;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Decimal point is never lit, so bit 7 is always zero.
  function automatic logic [SEG_BITS-1:0] bcd_to_seg(input logic [3:0] bcd);
    logic [SEG_BITS-1:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// -----------------------------------------------------------------------------
// bcd_to_7seg
// Purely combinational single-digit decoder.
// Ports:
//   i_bcd  [3:0] : BCD nibble
//   o_seg  [7:0] : active-high segments {dp,g,f,e,d,c,b,a}; 0xA-0xF -> dark
// -----------------------------------------------------------------------------
module bcd_to_7seg
  import segment_pkg::*;
(
  input  logic [3:0]          i_bcd,
  output logic [SEG_BITS-1:0] o_seg
);

  assign o_seg = bcd_to_seg(i_bcd);

endmodule

// File: rtl/segment_driver.sv
// -----------------------------------------------------------------------------
// segment_driver
// Serial driver for a chain of cascaded shift-register/latch LED drivers.
// Every frame: capture + decode the BCD word (LOAD), shift all segment bits
// out MSB first on a divided clock (SHIFT), pulse the latch (LATCH), then
// idle (GAP) and repeat.
// Parameters:
//   CLK_DIV    : i_clk cycles per half-period of o_ledClk (>= 1)
//   NUM_DIGITS : number of digits on the chain
//   GAP_CYCLES : idle cycles between latch and next frame
// Ports:
//   i_clk     : system clock (rising edge)
//   i_resetn  : asynchronous active-low reset
//   i_bcdData : packed BCD, digit k at [4k+3:4k], digit 0 rightmost
//   o_ledClk  : serial shift clock
//   o_data    : serial segment data, stable around o_ledClk rising edges
//   o_lat     : latch strobe, active-high
//   o_blank   : display blank, high until the first latch completes
// -----------------------------------------------------------------------------
module segment_driver
  import segment_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS,
  parameter int GAP_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_resetn,
  input  logic [4*NUM_DIGITS-1:0] i_bcdData,
  output logic                    o_ledClk,
  output logic                    o_data,
  output logic                    o_lat,
  output logic                    o_blank
);

  localparam int TOTAL_BITS = NUM_DIGITS * SEG_BITS;
  localparam int BIT_W      = $clog2(TOTAL_BITS);
  localparam int PERIOD     = 2 * CLK_DIV;
  localparam int CNT_MAX    = (PERIOD > GAP_CYCLES) ? PERIOD : GAP_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HALF_END   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PERIOD_END = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] GAP_END    = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(TOTAL_BITS - 1);

  state_t                  r_state;
  state_t                  w_nextState;
  logic [CNT_W-1:0]        r_cnt;
  logic [BIT_W-1:0]        r_bitCnt;
  logic [TOTAL_BITS-1:0]   r_shift;
  logic                    r_ledClk;
  logic                    r_data;
  logic                    r_lat;
  logic                    r_blank;
  logic [TOTAL_BITS-1:0]   w_segWord;
  logic                    w_halfEnd;
  logic                    w_periodEnd;
  logic                    w_lastBit;
  logic                    w_cntClear;

  // One decoder per digit; digit NUM_DIGITS-1 lands in the top byte so it
  // leaves the shift register first, dp before a within each byte.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
    bcd_to_7seg u_dec (
      .i_bcd (i_bcdData[4*k +: 4]),
      .o_seg (w_segWord[SEG_BITS*k +: SEG_BITS])
    );
  end

  assign w_halfEnd   = (r_cnt == HALF_END);
  assign w_periodEnd = (r_cnt == PERIOD_END);
  assign w_lastBit   = (r_bitCnt == LAST_BIT);

  // State register.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. SHIFT ends on the falling ledClk edge of the last bit;
  // LATCH lasts one full ledClk period with the shift clock held low.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_LOAD: begin
        w_nextState = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_periodEnd && w_lastBit) begin
          w_nextState = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (w_periodEnd) begin
          w_nextState = (GAP_CYCLES > 0) ? ST_GAP : ST_LOAD;
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_END) begin
          w_nextState = ST_LOAD;
        end
      end
      default: begin
        w_nextState = ST_LOAD;
      end
    endcase
  end

  // The one cycle counter restarts on every state change and at the end of
  // each bit period, so it times the ledClk halves, the latch and the gap.
  assign w_cntClear = (w_nextState != r_state) ||
                      ((r_state == ST_SHIFT) && w_periodEnd);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_cnt <= '0;
    end else if (w_cntClear) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Datapath and registered outputs. Data only moves on the cycle ledClk
  // falls (or when the frame is loaded), giving a full half period of setup
  // and hold around every rising edge. Zeros shift in behind the frame so
  // o_data returns low once the last bit has gone out.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_shift  <= '0;
      r_bitCnt <= '0;
      r_ledClk <= 1'b0;
      r_data   <= 1'b0;
      r_lat    <= 1'b0;
      r_blank  <= 1'b1;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_shift  <= w_segWord;
          r_data   <= w_segWord[TOTAL_BITS-1];
          r_bitCnt <= '0;
          r_ledClk <= 1'b0;
        end
        ST_SHIFT: begin
          if (w_halfEnd) begin
            r_ledClk <= 1'b1;
          end
          if (w_periodEnd) begin
            r_ledClk <= 1'b0;
            r_shift  <= {r_shift[TOTAL_BITS-2:0], 1'b0};
            r_data   <= r_shift[TOTAL_BITS-2];
            if (w_lastBit) begin
              r_bitCnt <= '0;
              r_lat    <= 1'b1;
            end else begin
              r_bitCnt <= r_bitCnt + 1'b1;
            end
          end
        end
        ST_LATCH: begin
          if (w_periodEnd) begin
            r_lat   <= 1'b0;
            r_blank <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_ledClk = r_ledClk;
  assign o_data   = r_data;
  assign o_lat    = r_lat;
  assign o_blank  = r_blank;

endmodule

// File: tb/tb_segment_driver.sv
// -----------------------------------------------------------------------------
// tb_segment_driver
// Table-driven bench for segment_driver with default parameters, plus
// hand-written sequences for mid-frame input change and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_segment_driver;

  localparam int NBITS       = 88;
  localparam int LAT_WIDTH   = 8;
  localparam int FRAME_LEN   = 729;
  localparam int FIRST_LAT   = 705;
  localparam int FRAME_BOUND = 2000;

  typedef struct {
    logic [43:0] bcd;
    logic [87:0] expBits;
    string       name;
  } vec_t;

  logic        i_clk;
  logic        i_resetn;
  logic [43:0] i_bcdData;
  logic        o_ledClk;
  logic        o_data;
  logic        o_lat;
  logic        o_blank;

  int testsRun;
  int testsFailed;
  int cycCount;
  int relCycle;

  vec_t vecs[4];

  segment_driver dut (
    .i_clk     (i_clk),
    .i_resetn  (i_resetn),
    .i_bcdData (i_bcdData),
    .o_ledClk  (o_ledClk),
    .o_data    (o_data),
    .o_lat     (o_lat),
    .o_blank   (o_blank)
  );

  // Free-running 100 MHz clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Cycle stamp used to measure latch position and frame period.
  always @(posedge i_clk) begin
    cycCount <= cycCount + 1;
  end

  task automatic checkOutput(input string name, input logic [87:0] act, input logic [87:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Hold reset for two cycles with the clock running, checking the outputs
  // sit at their reset values, then release at a falling edge.
  task automatic applyStimulus(input logic [43:0] bcd);
    @(negedge i_clk);
    i_bcdData = bcd;
    i_resetn  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      checkOutput("resetHold", {84'd0, o_ledClk, o_data, o_lat, o_blank}, 88'b0001);
    end
    i_resetn = 1'b1;
    relCycle = cycCount;
  endtask

  // Watch one frame up to the falling edge of the latch. Data is captured
  // on each ledClk rising edge; any data change while ledClk is high or any
  // ledClk activity during the latch counts as a violation.
  task automatic captureFrame(output logic [87:0] bits, output int edges, output int latW,
                              output int latRise, output int violations,
                              output logic blankHigh, output logic blankAfter, output logic ok);
    logic prevClk;
    logic prevData;
    prevClk    = o_ledClk;
    prevData   = o_data;
    bits       = '0;
    edges      = 0;
    latW       = 0;
    latRise    = 0;
    violations = 0;
    blankHigh  = 1'b0;
    blankAfter = 1'b1;
    ok         = 1'b0;
    for (int c = 0; c < FRAME_BOUND; c++) begin
      @(negedge i_clk);
      if (o_ledClk && !prevClk) begin
        if (edges < NBITS) bits[NBITS-1-edges] = o_data;
        edges++;
      end
      if ((o_data !== prevData) && o_ledClk) violations++;
      if (o_lat) begin
        if (latW == 0) latRise = cycCount;
        latW++;
        if (o_ledClk) violations++;
        if (o_blank) blankHigh = 1'b1;
      end else if (latW > 0) begin
        blankAfter = o_blank;
        ok = 1'b1;
        break;
      end
      prevClk  = o_ledClk;
      prevData = o_data;
    end
  endtask

  initial begin
    logic [87:0] bits;
    int          edges;
    int          latW;
    int          latRise;
    int          latRise2;
    int          viol;
    logic        blankHigh;
    logic        blankAfter;
    logic        ok;
    int          latSeen;

    testsRun    = 0;
    testsFailed = 0;
    cycCount    = 0;
    relCycle    = 0;
    i_resetn    = 1'b0;
    i_bcdData   = '0;

    vecs[0] = '{44'h0123456789,  88'h3F3F065B4F666D7D077F6F, "ascending"};
    vecs[1] = '{44'h98765432100, 88'h6F7F077D6D664F5B063F3F, "descending"};
    vecs[2] = '{44'hFFFFFFFFFFF, 88'h0,                      "allInvalid"};
    vecs[3] = '{44'hA5B3C8D0E1F, 88'h006D004F007F003F000600, "mixedInvalid"};

    // Two consecutive frames per vector: first after reset, then steady state.
    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].bcd);
      captureFrame(bits, edges, latW, latRise, viol, blankHigh, blankAfter, ok);
      checkOutput({vecs[v].name, "_done1"},    88'(ok), 88'd1);
      checkOutput({vecs[v].name, "_bits1"},    bits, vecs[v].expBits);
      checkOutput({vecs[v].name, "_edges1"},   88'(edges), 88'(NBITS));
      checkOutput({vecs[v].name, "_latW1"},    88'(latW), 88'(LAT_WIDTH));
      checkOutput({vecs[v].name, "_latPos"},   88'(latRise - relCycle), 88'(FIRST_LAT));
      checkOutput({vecs[v].name, "_viol1"},    88'(viol), 88'd0);
      checkOutput({vecs[v].name, "_blankOn"},  88'(blankHigh), 88'd1);
      checkOutput({vecs[v].name, "_blankOff"}, 88'(blankAfter), 88'd0);
      captureFrame(bits, edges, latW, latRise2, viol, blankHigh, blankAfter, ok);
      checkOutput({vecs[v].name, "_done2"},    88'(ok), 88'd1);
      checkOutput({vecs[v].name, "_bits2"},    bits, vecs[v].expBits);
      checkOutput({vecs[v].name, "_edges2"},   88'(edges), 88'(NBITS));
      checkOutput({vecs[v].name, "_period"},   88'(latRise2 - latRise), 88'(FRAME_LEN));
      checkOutput({vecs[v].name, "_viol2"},    88'(viol), 88'd0);
      checkOutput({vecs[v].name, "_blank2"},   88'(blankHigh | blankAfter), 88'd0);
    end

    // Input changes halfway through SHIFT must wait for the next LOAD.
    applyStimulus(vecs[0].bcd);
    fork
      captureFrame(bits, edges, latW, latRise, viol, blankHigh, blankAfter, ok);
      begin
        repeat (360) @(negedge i_clk);
        i_bcdData = vecs[1].bcd;
      end
    join
    checkOutput("midChange_oldFrame", bits, vecs[0].expBits);
    checkOutput("midChange_done1", 88'(ok), 88'd1);
    captureFrame(bits, edges, latW, latRise, viol, blankHigh, blankAfter, ok);
    checkOutput("midChange_newFrame", bits, vecs[1].expBits);
    checkOutput("midChange_done2", 88'(ok), 88'd1);

    // Reset in the middle of SHIFT, while ledClk is high: outputs drop at
    // once, no latch pulse appears, and a full frame follows release.
    applyStimulus(44'h88888888888);
    latSeen = 0;
    repeat (200) begin
      @(negedge i_clk);
      if (o_lat) latSeen++;
    end
    checkOutput("midReset_ledClkHighBefore", 88'(o_ledClk), 88'd1);
    i_resetn = 1'b0;
    #1;
    checkOutput("midReset_immediate", {84'd0, o_ledClk, o_data, o_lat, o_blank}, 88'b0001);
    checkOutput("midReset_noLatchBefore", 88'(latSeen), 88'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      checkOutput("midReset_hold", {84'd0, o_ledClk, o_data, o_lat, o_blank}, 88'b0001);
    end
    i_bcdData = vecs[0].bcd;
    i_resetn  = 1'b1;
    relCycle  = cycCount;
    captureFrame(bits, edges, latW, latRise, viol, blankHigh, blankAfter, ok);
    checkOutput("midReset_done",   88'(ok), 88'd1);
    checkOutput("midReset_bits",   bits, vecs[0].expBits);
    checkOutput("midReset_edges",  88'(edges), 88'(NBITS));
    checkOutput("midReset_latW",   88'(latW), 88'(LAT_WIDTH));
    checkOutput("midReset_latPos", 88'(latRise - relCycle), 88'(FIRST_LAT));
    checkOutput("midReset_blank",  88'(blankHigh), 88'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
